// File: rtl/rv32_cmp_pkg.sv
// Shared encodings for the RV32 comparator datapath: branch/SLT funct3 values
// and the requester port identifiers used to tag results.
package rv32_cmp_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;

   localparam logic PORT_BR  = 1'b0;
   localparam logic PORT_SLT = 1'b1;

   typedef struct packed {
      logic id;
      logic result;
      logic err;
   } rspFields_t;

endpackage

// File: rtl/cmp_share_ctrl_comp32b.sv
// COMP32b: 32-bit magnitude comparator; uMod selects unsigned (1) or
// two's-complement signed (0) ordering.
module COMP32b (
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        uMod,
   output logic        Less
);

   always_comb begin
      if (uMod) Less = (A < B);
      else      Less = ($signed(A) < $signed(B));
   end

endmodule

// File: rtl/cmp_share_ctrl.sv
// Round-robin arbiter that shares one COMP32b between the branch port and
// the SLT port, returning one tagged, registered result per accepted request.
module cmp_share_ctrl
   import rv32_cmp_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter logic        RR_INIT = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [2:0]      req0_op,
   input  logic [XLEN-1:0] req0_a,
   input  logic [XLEN-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [2:0]      req1_op,
   input  logic [XLEN-1:0] req1_a,
   input  logic [XLEN-1:0] req1_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic            rsp_result,
   output logic            rsp_err
);

   if (XLEN != 32) begin : gXlenCheck
      $error("cmp_share_ctrl: XLEN must be 32 to match COMP32b");
   end

   logic            lastGrant;
   logic            slotFree;
   logic            grantPort;
   logic            anyValid;
   logic            accept;
   logic [2:0]      selOp;
   logic [XLEN-1:0] selA;
   logic [XLEN-1:0] selB;
   logic            uMod;
   logic            less;
   logic            eq;
   rspFields_t      nextRsp;

   assign slotFree = !rsp_valid || rsp_ready;
   assign anyValid = req0_valid || req1_valid;
   assign accept   = slotFree && anyValid;

   // On a tie the port that did not win last time goes next; when idle the
   // mux rests on port 0 so the comparator never sees floating operands.
   always_comb begin
      if (req0_valid && req1_valid) grantPort = ~lastGrant;
      else if (req1_valid)          grantPort = PORT_SLT;
      else                          grantPort = PORT_BR;
   end

   assign req0_ready = slotFree && req0_valid && (grantPort == PORT_BR);
   assign req1_ready = slotFree && req1_valid && (grantPort == PORT_SLT);

   always_comb begin
      if (grantPort == PORT_SLT) begin
         selOp = req1_op;
         selA  = req1_a;
         selB  = req1_b;
         uMod  = req1_op[0];
      end else begin
         selOp = req0_op;
         selA  = req0_a;
         selB  = req0_b;
         uMod  = req0_op[1];
      end
   end

   COMP32b uComp (
      .A    (selA),
      .B    (selB),
      .uMod (uMod),
      .Less (less)
   );

   assign eq = (selA == selB);

   always_comb begin
      nextRsp.id     = grantPort;
      nextRsp.result = 1'b0;
      nextRsp.err    = 1'b0;
      if (grantPort == PORT_BR) begin
         case (selOp)
            F3_BEQ:           nextRsp.result = eq;
            F3_BNE:           nextRsp.result = !eq;
            F3_BLT, F3_BLTU:  nextRsp.result = less;
            F3_BGE, F3_BGEU:  nextRsp.result = !less;
            default:          nextRsp.err    = 1'b1;
         endcase
      end else begin
         case (selOp)
            F3_SLT, F3_SLTU:  nextRsp.result = less;
            default:          nextRsp.err    = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= 1'b0;
         rsp_err    <= 1'b0;
         lastGrant  <= RR_INIT;
      end else if (accept) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= nextRsp.id;
         rsp_result <= nextRsp.result;
         rsp_err    <= nextRsp.err;
         lastGrant  <= grantPort;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule
